// File: rtl/dot_product_if.sv
// Host-side bundle for the dot-product engine: two packed operand vectors in,
// registered result plus one-cycle strobe out.
interface dot_product_if #(
  parameter int MATRIXSIZE = 5,
  parameter int WIDTH      = 8
);
  logic [MATRIXSIZE*WIDTH-1:0] a_flat;
  logic [MATRIXSIZE*WIDTH-1:0] b_flat;
  logic [WIDTH-1:0]            o;
  logic                        o_valid;

  modport master (output a_flat, output b_flat, input  o, input  o_valid);
  modport slave  (input  a_flat, input  b_flat, output o, output o_valid);
endinterface

// File: rtl/dot_product.sv
// Free-running sequential dot product: one multiply-accumulate per clock,
// publishing sum(a[i]*b[i]) every MATRIXSIZE cycles. Optional macro
// DOT_PRODUCT_SATURATE_EN clamps the published result instead of wrapping it.
module dot_product #(
  parameter int MATRIXSIZE = 5,
  parameter int WIDTH      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  dot_product_if.slave bus
);

  localparam int PROD_W = 2 * WIDTH;
  localparam int ACC_W  = PROD_W + $clog2(MATRIXSIZE);
  localparam int IDX_W  = (MATRIXSIZE > 1) ? $clog2(MATRIXSIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MATRIXSIZE - 1);

  logic [IDX_W-1:0]            r_idx;
  logic [MATRIXSIZE*WIDTH-1:0] r_snap_a;
  logic [MATRIXSIZE*WIDTH-1:0] r_snap_b;
  logic [ACC_W-1:0]            r_acc;
  logic [WIDTH-1:0]            r_o;
  logic                        r_o_valid;

  logic                        w_first;
  logic                        w_last;
  logic [IDX_W-1:0]            w_idx_next;
  logic [WIDTH-1:0]            w_elem_a;
  logic [WIDTH-1:0]            w_elem_b;
  logic [PROD_W-1:0]           w_prod;
  logic [ACC_W-1:0]            w_acc_next;

  function automatic logic [WIDTH-1:0] reduce_result(input logic [ACC_W-1:0] acc);
`ifdef DOT_PRODUCT_SATURATE_EN
    if (acc > ACC_W'({WIDTH{1'b1}}))
      return {WIDTH{1'b1}};
    else
      return acc[WIDTH-1:0];
`else
    return WIDTH'(acc);
`endif
  endfunction

  assign w_first    = (r_idx == '0);
  assign w_last     = (r_idx == LAST_IDX);
  assign w_idx_next = w_last ? '0 : r_idx + IDX_W'(1);

  // Element 0 comes straight from the live inputs on the capture edge; later
  // elements come from the snapshot so mid-pass input changes are ignored.
  always_comb begin
    w_elem_a = '0;
    w_elem_b = '0;
    for (int i = 0; i < MATRIXSIZE; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_elem_a = r_snap_a[i*WIDTH +: WIDTH];
        w_elem_b = r_snap_b[i*WIDTH +: WIDTH];
      end
    end
    if (w_first) begin
      w_elem_a = bus.a_flat[WIDTH-1:0];
      w_elem_b = bus.b_flat[WIDTH-1:0];
    end
  end

  assign w_prod     = PROD_W'(w_elem_a) * PROD_W'(w_elem_b);
  assign w_acc_next = w_first ? ACC_W'(w_prod) : r_acc + ACC_W'(w_prod);

  // Stage boundary: accumulate and publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_snap_a  <= '0;
      r_snap_b  <= '0;
      r_acc     <= '0;
      r_o       <= '0;
      r_o_valid <= 1'b0;
    end else begin
      r_idx     <= w_idx_next;
      r_acc     <= w_acc_next;
      r_o_valid <= w_last;
      if (w_first) begin
        r_snap_a <= bus.a_flat;
        r_snap_b <= bus.b_flat;
      end
      if (w_last)
        r_o <= reduce_result(w_acc_next);
    end
  end

  assign bus.o       = r_o;
  assign bus.o_valid = r_o_valid;

endmodule

// File: tb/tb_dot_product.sv
// Bench for dot_product: a MATRIXSIZE=5 instance and a MATRIXSIZE=1 instance
// compared edge by edge against a pass-level arithmetic model.
module tb_dot_product;

  localparam int M = 5;
  localparam int W = 8;
  localparam longint unsigned MAXV = (64'd1 << W) - 1;
`ifdef DOT_PRODUCT_SATURATE_EN
  localparam longint unsigned OVF5_EXP = 255;
  localparam longint unsigned OVF1_EXP = 255;
`else
  localparam longint unsigned OVF5_EXP = 5;
  localparam longint unsigned OVF1_EXP = 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dot_product_if #(.MATRIXSIZE(M), .WIDTH(W)) bus5 ();
  dot_product_if #(.MATRIXSIZE(1), .WIDTH(W)) bus1 ();

  dot_product #(.MATRIXSIZE(M), .WIDTH(W)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));
  dot_product #(.MATRIXSIZE(1), .WIDTH(W)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int n_cmp = 0;
  int n_err = 0;

  int unsigned     va [M];
  int unsigned     vb [M];
  int unsigned     a1, b1;
  bit              in_reset;
  int              e5;
  longint unsigned exp_sum5;
  longint unsigned exp_o5, exp_v5, exp_o1, exp_v1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned reduce(input longint unsigned s);
`ifdef DOT_PRODUCT_SATURATE_EN
    return (s > MAXV) ? MAXV : s;
`else
    return s % (MAXV + 1);
`endif
  endfunction

  function automatic longint unsigned dot();
    longint unsigned s = 0;
    for (int i = 0; i < M; i++) s += longint'(va[i]) * longint'(vb[i]);
    return s;
  endfunction

  task automatic drive();
    for (int i = 0; i < M; i++) begin
      bus5.a_flat[i*W +: W] = W'(va[i]);
      bus5.b_flat[i*W +: W] = W'(vb[i]);
    end
    bus1.a_flat = W'(a1);
    bus1.b_flat = W'(b1);
  endtask

  task automatic set_basic();
    va = '{4, 6, 8, 4, 2};
    vb = '{3, 9, 1, 5, 1};
  endtask

  // Advance one rising edge, update the model with the inputs seen at that edge,
  // then compare all outputs.
  task automatic step();
    @(posedge clk);
    #1;
    if (in_reset) begin
      exp_o5 = 0; exp_v5 = 0; exp_o1 = 0; exp_v1 = 0;
    end else begin
      if (e5 % M == 0) exp_sum5 = dot();
      if (e5 % M == M - 1) begin
        exp_o5 = reduce(exp_sum5);
        exp_v5 = 1;
      end else begin
        exp_v5 = 0;
      end
      e5++;
      exp_o1 = reduce(longint'(a1) * longint'(b1));
      exp_v1 = 1;
    end
    check("o",          bus5.o,       exp_o5);
    check("o_valid",    bus5.o_valid, exp_v5);
    check("o_m1",       bus1.o,       exp_o1);
    check("o_valid_m1", bus1.o_valid, exp_v1);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n    = 1'b1;
    in_reset = 1'b0;
    e5       = 0;
  endtask

  initial begin
    in_reset = 1'b1;
    exp_sum5 = 0;
    e5       = 0;
    set_basic();
    a1 = 7; b1 = 9;
    drive();
    #1;
    check("reset_o",       bus5.o,       0);
    check("reset_valid",   bus5.o_valid, 0);
    check("reset_o_m1",    bus1.o,       0);
    check("reset_vld_m1",  bus1.o_valid, 0);
    repeat (2) step();
    release_reset();

    // Basic pass, repeated
    for (int p = 0; p < 3; p++) begin
      repeat (M) step();
      check("basic96",   bus5.o,       96);
      check("basic_vld", bus5.o_valid, 1);
    end
    check("m1_63", bus1.o, 63);

    // B cleared right after the capture edge
    step();
    for (int i = 0; i < M; i++) vb[i] = 0;
    drive();
    repeat (M - 1) step();
    check("midpass_96", bus5.o, 96);
    repeat (M) step();
    check("midpass_next0", bus5.o, 0);
    check("midpass_vld",   bus5.o_valid, 1);

    // Zero vectors
    for (int i = 0; i < M; i++) va[i] = 0;
    drive();
    repeat (M) step();
    check("zero", bus5.o, 0);

    // Overflow
    for (int i = 0; i < M; i++) begin va[i] = 255; vb[i] = 255; end
    a1 = 255; b1 = 255;
    drive();
    repeat (M) step();
    check("ovf",    bus5.o, OVF5_EXP);
    check("ovf_m1", bus1.o, OVF1_EXP);

    // Reset in the middle of a pass
    set_basic();
    a1 = 7; b1 = 9;
    drive();
    repeat (3) step();
    rst_n    = 1'b0;
    in_reset = 1'b1;
    #1;
    check("async_o",      bus5.o,       0);
    check("async_valid",  bus5.o_valid, 0);
    check("async_o_m1",   bus1.o,       0);
    check("async_vld_m1", bus1.o_valid, 0);
    exp_o5 = 0; exp_v5 = 0;
    repeat (2) step();
    release_reset();
    repeat (M - 1) step();
    check("rst_no_early", bus5.o_valid, 0);
    step();
    check("rst_first96", bus5.o, 96);

    // Randomized passes with occasional mid-pass input churn
    for (int p = 0; p < 40; p++) begin
      for (int k = 0; k < M; k++) begin
        if (k == 0 || $urandom_range(0, 2) == 0) begin
          for (int i = 0; i < M; i++) begin
            va[i] = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
            vb[i] = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
          end
        end
        a1 = $urandom_range(0, 255);
        b1 = $urandom_range(0, 255);
        drive();
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dot_product.md
Name: dot_product

Overview:
- Sequential integer dot-product engine for the vector accelerator datapath.
- Takes two flattened vectors of MATRIXSIZE unsigned elements and computes sum(a[i]*b[i]) with one multiply-accumulate per clock.
- Runs free, in repeating passes of MATRIXSIZE cycles. Each pass publishes a registered result and a one-cycle valid strobe to the host-facing register layer.

Parameters:
- MATRIXSIZE, 5, number of elements per vector (>=1).
- WIDTH, 8, bit width of each element and of the result o.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a_flat  input  MATRIXSIZE*WIDTH  vector A; element i at bits [i*WIDTH +: WIDTH], unsigned.
- b_flat  input  MATRIXSIZE*WIDTH  vector B; same packing as a_flat.
- o  output  WIDTH  registered dot-product result of the last completed pass.
- o_valid  output  1  high for exactly one cycle when o is updated.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n low, asynchronous, regardless of clk):
  - o=0, o_valid=0, element index idx=0.
  - Accumulator and snapshot registers cleared.
- Element index: idx counts 0..MATRIXSIZE-1, then wraps to 0.
- Rising edge with idx==0:
  - Snapshot a_flat/b_flat into internal registers.
  - acc <= a[0]*b[0], taken from the live inputs.
- Rising edge with idx==k (k>0): acc <= acc + snap_a[k]*snap_b[k].
- Rising edge with idx==MATRIXSIZE-1: o <= the value acc takes at that edge, reduced to WIDTH bits (see Optional Feature); o_valid <= 1.
- All other edges: o_valid <= 0, o holds.
- Timing:
  - First result appears at the MATRIXSIZE-th rising edge after rst_n deasserts.
  - Subsequent results follow every MATRIXSIZE edges.
  - Latency from snapshot to o is MATRIXSIZE-1 edges after the capture edge.
- Input sampling: changes to a_flat/b_flat after the idx==0 edge do not affect the current pass; they are picked up at the next pass.
- Arithmetic:
  - Products are full 2*WIDTH bits.
  - Accumulator width is 2*WIDTH + clog2(MATRIXSIZE), wide enough that it never overflows internally.
- MATRIXSIZE==1: every edge is both capture and publish; o <= a[0]*b[0] reduced, and o_valid stays high continuously.
- Reset mid-pass: the partial sum is discarded, o returns to 0, and the next pass starts at idx=0 after release.
- No handshake or backpressure: a consumer must sample o when o_valid=1, or read the stable o at any time between strobes.

Optional Feature:
- Macro: DOT_PRODUCT_SATURATE_EN.
- Defined: if the full accumulator value exceeds 2^WIDTH-1, o is set to 2^WIDTH-1 (all ones); otherwise o takes the exact value.
- Not defined: o takes the low WIDTH bits of the full sum (modulo 2^WIDTH wrap).
- The accumulator itself behaves identically in both builds.

Test Plan:
- Basic pass: A=[4,6,8,4,2], B=[3,9,1,5,1], reset, then release -> at the 5th rising edge o=96 with o_valid=1 for one cycle; o=96 and o_valid pulses again every 5 cycles.
- Overflow: all elements 255 in both vectors (sum 325125):
  - wrap build -> o=5;
  - DOT_PRODUCT_SATURATE_EN build -> o=255.
- Mid-pass input change: start with the basic vectors, switch B to all zeros at the 2nd edge of the pass -> that pass still yields 96; the next pass yields 0.
- Reset mid-pass: assert rst_n=0 at the 3rd edge of a pass -> o=0 and o_valid=0 immediately (asynchronous); after release, the first result arrives at the 5th edge.
- Zero vectors: A=B=0 -> o=0 with o_valid pulsing every 5 cycles.
- MATRIXSIZE=1, WIDTH=8, a=7, b=9 -> o=63 from the first edge after release; o_valid constantly 1.
